// File: rtl/i2c_cfg_sequencer.sv
// rtl/i2c_cfg_sequencer.sv - walks a (reg, data) table and issues each entry as an I2C write
module i2c_cfg_sequencer #(
    parameter int ROM_AW        = 8,
    parameter int DELAY_CYCLES  = 1_000_000,
    parameter int MAX_RETRY     = 3,
    parameter int ISSUE_TIMEOUT = 65535,
    parameter int AUTO_START    = 1
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_start,
    output logic [ROM_AW-1:0] o_rom_addr,
    input  logic [15:0]       i_rom_data,
    output logic              o_wr,
    output logic [7:0]        o_reg_addr,
    output logic [7:0]        o_wdata,
    input  logic              i_busy,
    input  logic              i_nack_slave,
    input  logic              i_nack_addr,
    input  logic              i_nack_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error,
    output logic [ROM_AW-1:0] o_err_index,
    output logic [2:0]        o_err_code
);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT, S_CHECK, S_DELAY, S_DONE, S_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [ROM_AW-1:0] index_q, index_d;
    logic [7:0]        reg_q, reg_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [31:0]       dly_q, dly_d;
    logic [31:0]       tmo_q, tmo_d;
    logic [31:0]       retry_q, retry_d;
    logic [2:0]        nack_q, nack_d;
    logic [ROM_AW-1:0] err_index_q, err_index_d;
    logic [2:0]        err_code_q, err_code_d;
    // Cleared by reset, set on every later cycle: marks the first post-reset cycle for auto start.
    logic              boot_q;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q     <= S_IDLE;
            index_q     <= '0;
            reg_q       <= '0;
            wdata_q     <= '0;
            dly_q       <= '0;
            tmo_q       <= '0;
            retry_q     <= '0;
            nack_q      <= '0;
            err_index_q <= '0;
            err_code_q  <= '0;
            boot_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            reg_q       <= reg_d;
            wdata_q     <= wdata_d;
            dly_q       <= dly_d;
            tmo_q       <= tmo_d;
            retry_q     <= retry_d;
            nack_q      <= nack_d;
            err_index_q <= err_index_d;
            err_code_q  <= err_code_d;
            boot_q      <= 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        reg_d       = reg_q;
        wdata_d     = wdata_q;
        dly_d       = dly_q;
        tmo_d       = tmo_q;
        retry_d     = retry_q;
        nack_d      = nack_q;
        err_index_d = err_index_q;
        err_code_d  = err_code_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (i_start || (state_q == S_IDLE && AUTO_START != 0 && !boot_q)) begin
                    state_d     = S_FETCH;
                    index_d     = '0;
                    err_index_d = '0;
                    err_code_d  = '0;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                if (i_rom_data == 16'hFFFF) begin
                    state_d = S_DONE;
                end else if (i_rom_data == 16'hFFF0) begin
                    dly_d   = 32'(DELAY_CYCLES);
                    state_d = S_DELAY;
                end else begin
                    reg_d   = i_rom_data[15:8];
                    wdata_d = i_rom_data[7:0];
                    retry_d = '0;
                    tmo_d   = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (i_busy) begin
                    state_d = S_WAIT;
                end else if (tmo_q == 32'(ISSUE_TIMEOUT - 1)) begin
                    err_index_d = index_q;
                    err_code_d  = 3'b000;
                    state_d     = S_ERROR;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
            end
            S_WAIT: begin
                if (!i_busy) begin
                    nack_d  = {i_nack_slave, i_nack_addr, i_nack_data};
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (nack_q == 3'b000) begin
                    index_d = index_q + 1'b1;
                    state_d = S_FETCH;
                end else if (retry_q < 32'(MAX_RETRY)) begin
                    retry_d = retry_q + 32'd1;
                    tmo_d   = '0;
                    state_d = S_ISSUE;
                end else begin
                    err_index_d = index_q;
                    err_code_d  = nack_q;
                    state_d     = S_ERROR;
                end
            end
            S_DELAY: begin
                if (dly_q == 32'd0) begin
                    index_d = index_q + 1'b1;
                    state_d = S_FETCH;
                end else begin
                    dly_d = dly_q - 32'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign o_rom_addr  = index_q;
    assign o_wr        = (state_q == S_ISSUE);
    assign o_reg_addr  = reg_q;
    assign o_wdata     = wdata_q;
    assign o_busy      = !(state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);
    assign o_done      = (state_q == S_DONE);
    assign o_error     = (state_q == S_ERROR);
    assign o_err_index = err_index_q;
    assign o_err_code  = err_code_q;

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// tb/tb_i2c_cfg_sequencer.sv - directed self-checking bench for i2c_cfg_sequencer
module tb_i2c_cfg_sequencer;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [15:0]   rom_data = 16'h0;
    logic          wr;
    logic [7:0]    reg_addr, wdata;
    logic          busy = 1'b0;
    logic [2:0]    nk = 3'b000;
    logic          seq_busy, done, error;
    logic [AW-1:0] err_index;
    logic [2:0]    err_code;

    logic [15:0]   rom [0:(1<<AW)-1];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;

    // i2c_master model state and knobs
    int            init_delay = 1;
    int            hc = 0;
    int            bcnt = 0;
    logic [7:0]    cur_reg = 8'h0;
    logic [7:0]    nack_reg = 8'h0;
    int            nack_times = 0;
    int            nack_used = 0;
    logic [2:0]    nack_val = 3'b000;
    int            wr_samples = 0;
    logic [7:0]    log_reg[$];
    logic [7:0]    log_dat[$];
    int            start_cyc[$];
    int            end_cyc[$];

    i2c_cfg_sequencer #(
        .ROM_AW(AW), .DELAY_CYCLES(100), .MAX_RETRY(3), .ISSUE_TIMEOUT(65535), .AUTO_START(1)
    ) dut (
        .i_clk(clk), .i_rstn(rstn), .i_start(start),
        .o_rom_addr(rom_addr), .i_rom_data(rom_data),
        .o_wr(wr), .o_reg_addr(reg_addr), .o_wdata(wdata),
        .i_busy(busy), .i_nack_slave(nk[2]), .i_nack_addr(nk[1]), .i_nack_data(nk[0]),
        .o_busy(seq_busy), .o_done(done), .o_error(error),
        .o_err_index(err_index), .o_err_code(err_code)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rom_data <= rom[rom_addr];

    always @(negedge clk) begin
        if (!rstn) begin
            busy = 1'b0;
            hc   = 0;
            nk   = 3'b000;
        end else if (busy) begin
            if (bcnt == 0) begin
                busy = 1'b0;
                if (cur_reg == nack_reg && (nack_times < 0 || nack_used < nack_times)) begin
                    nk = nack_val;
                    nack_used++;
                end else begin
                    nk = 3'b000;
                end
                end_cyc.push_back(cyc);
            end else begin
                bcnt--;
            end
        end else if (wr) begin
            wr_samples++;
            hc++;
            if (hc >= init_delay) begin
                busy    = 1'b1;
                bcnt    = 3;
                hc      = 0;
                nk      = 3'b000;
                cur_reg = reg_addr;
                log_reg.push_back(reg_addr);
                log_dat.push_back(wdata);
                start_cyc.push_back(cyc);
            end
        end
    end

    task automatic load_table(input logic [15:0] w0, input logic [15:0] w1,
                              input logic [15:0] w2, input logic [15:0] w3);
        for (int i = 0; i < (1 << AW); i++) rom[i] = 16'hFFFF;
        rom[0] = w0; rom[1] = w1; rom[2] = w2; rom[3] = w3;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic wait_end(input string name);
        int n = 0;
        while (!(done || error) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(done || error)) begin
            errors++;
            $display("FAIL %s timeout: done=%0b error=%0b required completion", name, done, error);
        end
    endtask

    task automatic test_reset();
        load_table(16'h1280, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        @(negedge clk);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({wr, seq_busy, done, error, err_index, err_code, reg_addr, wdata, rom_addr} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: wr=%0b busy=%0b done=%0b err=%0b idx=%0d code=%0b reg=%h dat=%h addr=%0d required all 0",
                     wr, seq_busy, done, error, err_index, err_code, reg_addr, wdata, rom_addr);
        end
    endtask

    task automatic test_basic();
        int base = log_reg.size();
        int ws = wr_samples;
        rstn = 1'b1;
        wait_end("basic");
        checks++;
        if (done !== 1'b1 || error !== 1'b0) begin
            errors++;
            $display("FAIL basic_status: done=%0b error=%0b required 1 0", done, error);
        end
        checks++;
        if (log_reg.size() - base != 1 || log_reg[base] !== 8'h12 || log_dat[base] !== 8'h80) begin
            errors++;
            $display("FAIL basic_write: count=%0d reg=%h dat=%h required 1 12 80",
                     log_reg.size() - base, log_reg[base], log_dat[base]);
        end
        checks++;
        if (wr_samples - ws != 1) begin
            errors++;
            $display("FAIL basic_wr_len: got %0d cycles required 1", wr_samples - ws);
        end
        checks++;
        if (rom_addr !== 4'd1) begin
            errors++;
            $display("FAIL basic_end_addr: got %0d required 1", rom_addr);
        end
    endtask

    task automatic test_init_stall();
        int base;
        int ws;
        init_delay = 70;
        do_reset();
        base = log_reg.size();
        ws = wr_samples;
        wait_end("init_stall");
        checks++;
        if (wr_samples - ws != 70) begin
            errors++;
            $display("FAIL stall_wr_len: got %0d cycles required 70", wr_samples - ws);
        end
        checks++;
        if (log_reg.size() - base != 1 || done !== 1'b1) begin
            errors++;
            $display("FAIL stall_txn: count=%0d done=%0b required 1 1", log_reg.size() - base, done);
        end
        init_delay = 1;
    endtask

    task automatic test_delay();
        int base;
        int gap;
        load_table(16'h1280, 16'hFFF0, 16'h1104, 16'hFFFF);
        do_reset();
        base = log_reg.size();
        wait_end("delay");
        checks++;
        if (log_reg.size() - base != 2 || log_reg[base+1] !== 8'h11 || log_dat[base+1] !== 8'h04) begin
            errors++;
            $display("FAIL delay_writes: count=%0d reg=%h dat=%h required 2 11 04",
                     log_reg.size() - base, log_reg[base+1], log_dat[base+1]);
        end
        gap = start_cyc[base+1] - end_cyc[base];
        checks++;
        if (gap < 100 || gap > 110) begin
            errors++;
            $display("FAIL delay_gap: got %0d cycles required 100..110", gap);
        end
    endtask

    task automatic test_retry();
        int base;
        load_table(16'h1280, 16'h3A55, 16'hFFFF, 16'hFFFF);
        nack_reg = 8'h3A; nack_times = 2; nack_used = 0; nack_val = 3'b001;
        do_reset();
        base = log_reg.size();
        wait_end("retry");
        checks++;
        if (log_reg.size() - base != 4 || log_reg[base+3] !== 8'h3A) begin
            errors++;
            $display("FAIL retry_count: got %0d writes required 4", log_reg.size() - base);
        end
        checks++;
        if (done !== 1'b1 || error !== 1'b0) begin
            errors++;
            $display("FAIL retry_status: done=%0b error=%0b required 1 0", done, error);
        end
        nack_times = 0;
    endtask

    task automatic test_error_restart();
        int base;
        load_table(16'h1280, 16'h1104, 16'h3A55, 16'hFFFF);
        nack_reg = 8'h3A; nack_times = -1; nack_used = 0; nack_val = 3'b100;
        do_reset();
        base = log_reg.size();
        wait_end("error");
        checks++;
        if (log_reg.size() - base != 6) begin
            errors++;
            $display("FAIL error_attempts: got %0d writes required 6", log_reg.size() - base);
        end
        checks++;
        if (error !== 1'b1 || done !== 1'b0 || err_index !== 4'd2 || err_code !== 3'b100) begin
            errors++;
            $display("FAIL error_status: err=%0b done=%0b idx=%0d code=%b required 1 0 2 100",
                     error, done, err_index, err_code);
        end
        nack_times = 0;
        base = log_reg.size();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (error !== 1'b0 || err_index !== 4'd0 || err_code !== 3'b000 || seq_busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_clear: err=%0b idx=%0d code=%b busy=%0b required 0 0 000 1",
                     error, err_index, err_code, seq_busy);
        end
        wait_end("restart");
        checks++;
        if (done !== 1'b1 || log_reg.size() - base != 3 || log_reg[base] !== 8'h12) begin
            errors++;
            $display("FAIL restart_run: done=%0b count=%0d first=%h required 1 3 12",
                     done, log_reg.size() - base, log_reg[base]);
        end
    endtask

    task automatic test_reset_in_wait();
        int base;
        int n = 0;
        load_table(16'h1280, 16'h1104, 16'hFFFF, 16'hFFFF);
        do_reset();
        base = log_reg.size();
        while (log_reg.size() - base < 2 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        checks++;
        if ({wr, seq_busy, done, error, err_index, err_code} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: wr=%0b busy=%0b done=%0b err=%0b idx=%0d code=%b required all 0",
                     wr, seq_busy, done, error, err_index, err_code);
        end
        repeat (2) @(negedge clk);
        base = log_reg.size();
        rstn = 1'b1;
        wait_end("midreset_restart");
        checks++;
        if (done !== 1'b1 || log_reg.size() - base != 2 || log_reg[base] !== 8'h12 || log_reg[base+1] !== 8'h11) begin
            errors++;
            $display("FAIL midreset_restart: done=%0b count=%0d first=%h required 1 2 12",
                     done, log_reg.size() - base, log_reg[base]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_init_stall();
        test_delay();
        test_retry();
        test_error_restart();
        test_reset_in_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2c_cfg_sequencer.md
Name: i2c_cfg_sequencer

Overview:
Walks a table of (register address, data) pairs and issues each as a single-byte I2C write through i2c_master, one transaction at a time. Typical use is bring-up of a camera sensor at slave 0x42, e.g. soft reset with 0x12 = 0x80, then the register load. Sits between a table ROM and i2c_master's command port. Supports delay markers, per-entry NACK retry and a completion/error summary.

Parameters:
- ROM_AW, 8: table address width; the table holds up to 2^ROM_AW entries.
- DELAY_CYCLES, 1_000_000: clock cycles waited on a delay marker (10 ms at 100 MHz).
- MAX_RETRY, 3: re-attempts per entry after a NACK before declaring an error.
- ISSUE_TIMEOUT, 65535: cycles o_wr may stay high without i_busy rising before an error is declared.
- AUTO_START, 1: when 1, the sequence starts automatically on the first cycle after reset release.

Ports:
- i_clk, in, 1: system clock.
- i_rstn, in, 1: active-low reset, synchronous to i_clk.
- i_start, in, 1: single-cycle pulse; starts or restarts the sequence from entry 0. Honoured only in IDLE, DONE or ERROR.
- o_rom_addr, out, ROM_AW: table read address.
- i_rom_data, in, 16: table word [15:8] = reg addr, [7:0] = data; valid 1 cycle after o_rom_addr.
- o_wr, out, 1: write request to i2c_master.
- o_reg_addr, out, 8: register address to i2c_master.
- o_wdata, out, 8: write data to i2c_master.
- i_busy, in, 1: i2c_master o_busy.
- i_nack_slave, in, 1: i2c_master NACK flag, slave address frame.
- i_nack_addr, in, 1: i2c_master NACK flag, register address frame.
- i_nack_data, in, 1: i2c_master NACK flag, data frame.
- o_busy, out, 1: high from sequence start until DONE or ERROR.
- o_done, out, 1: level; table completed without error.
- o_error, out, 1: level; sequence aborted.
- o_err_index, out, ROM_AW: entry index at abort.
- o_err_code, out, 3: {nack_slave, nack_addr, nack_data} of the last failed attempt; 3'b000 means timeout.

Behaviour:
- Reset (i_rstn = 0 at a clock edge) returns to IDLE and zeroes every output and counter. This applies mid-transaction too: o_wr drops on the next edge, and the i2c_master keeps its own state.
- Table word 16'hFFFF = end of table. Word 16'hFFF0 = delay marker: wait DELAY_CYCLES, then continue. Every other word is a write entry.
- States:
  - IDLE: enter FETCH with index = 0 on an i_start pulse, or on the first post-reset cycle if AUTO_START = 1.
  - FETCH: drive o_rom_addr = index; go to DECODE next cycle.
  - DECODE: latch i_rom_data.
    - FFFF goes to DONE.
    - FFF0 loads the delay counter and goes to DELAY.
    - Otherwise load o_reg_addr/o_wdata, clear the retry count and go to ISSUE.
  - ISSUE: hold o_wr = 1 until i_busy = 1 is sampled; this covers i2c_master ignoring requests during its init. Then drop o_wr on that same edge and go to WAIT. If ISSUE_TIMEOUT cycles pass without i_busy, go to ERROR with code 000.
  - WAIT: stay while i_busy = 1. On the first cycle i_busy = 0, sample the three NACK flags and go to CHECK.
  - CHECK: if no NACK, index++ and go to FETCH. If NACK and retry < MAX_RETRY, retry++ and go to ISSUE. Otherwise go to ERROR.
  - DELAY: count down to 0, then index++ and go to FETCH.
  - DONE: o_done = 1.
  - ERROR: o_error = 1; o_err_index and o_err_code are latched.
  - From DONE or ERROR, an i_start pulse clears o_done, o_error and the error fields and restarts at entry 0.
- Entry at the highest index that is not FFFF: index wraps to 0 and the sequence continues. A full table with no terminator therefore repeats; this is legal but flagged by the bench.
- o_reg_addr and o_wdata stay stable from entering ISSUE until leaving WAIT.
- i_start while o_busy = 1 is ignored.
- o_wr is never high in any state other than ISSUE.
- Timing: each entry costs 2 cycles (FETCH, DECODE) plus the handshake. o_done rises 2 cycles after the FFFF address is driven.

Test Plan:
- Reset release with AUTO_START = 1 and table {1280, FFFF}, bench model acking: exactly one write of reg 0x12 = 0x80. o_done rises; o_error = 0; o_wr pulse ends on the cycle i_busy is first seen high.
- Model holds i_busy = 0 for 70 cycles after o_wr rises (master init), then acks: o_wr stays high for 70 cycles; one transaction only; sequence completes.
- Table {1280, FFF0, 1104, FFFF} with DELAY_CYCLES = 100: the second write starts no earlier than 100 cycles after the first completes.
- Model NACKs the data frame on entry 1 twice, then acks (MAX_RETRY = 3): entry 1 is issued 3 times and the sequence completes with o_done = 1.
- Model always NACKs the slave frame on entry 2: 4 attempts, then o_error = 1, o_err_index = 2, o_err_code = 3'b100. A later i_start clears the error and restarts at entry 0.
- Reset asserted during WAIT of entry 1: o_wr = 0 and all status outputs are 0 after the edge. With AUTO_START = 1, the sequence restarts from entry 0.
